spi_ram_bridge: RTL and testbench

SPI responder (slave) that lets an external SPI master load and read back the CPU's 8-bit-address, 32-bit-data single-port program/data RAM. It is the other end of the processor's SPI link: the external master initiates frames and this block answers them, acting as a memory-port initiator while it holds the CPU off via `cpu_hold`. It sits between the board SPI pins and the RAM port mux in front of `single_port_ram`.

---
 rtl/spi_ram_bridge_if.sv | 27 ++
 rtl/spi_ram_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_ram_bridge.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_bridge_if.sv
// Board SPI pins plus the RAM port as seen by spi_ram_bridge. There is no valid/ready
// handshake: mem_we is a one-cycle write strobe, and mem_rdata must be valid one clock after mem_addr.
interface spi_ram_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  cpu_hold;

  modport slave (
    input  sclk, cs_n, mosi, mem_rdata,
    output miso, miso_oe, mem_addr, mem_wdata, mem_we, cpu_hold
  );

  modport master (
    output sclk, cs_n, mosi, mem_rdata,
    input  miso, miso_oe, mem_addr, mem_wdata, mem_we, cpu_hold
  );
endinterface

// File: rtl/spi_ram_bridge.sv
// SPI mode-0 responder giving an external master read/write access to the CPU RAM.
// Optional SPI_BRIDGE_ID_EN: command 0x9F streams the constant ID word 32'h5350_4931.
module spi_ram_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  spi_ram_bridge_if.slave bus,
  output logic [2:0]      state_o
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_WDATA  = 3'd3,
    S_RDATA  = 3'd4,
    S_IGNORE = 3'd5
  } state_e;

  localparam logic [7:0]            CMD_WRITE = 8'h02;
  localparam logic [7:0]            CMD_READ  = 8'h03;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
`ifdef SPI_BRIDGE_ID_EN
  localparam logic [7:0]            CMD_ID    = 8'h9F;
  localparam logic [DATA_WIDTH-1:0] ID_WORD   = 32'h5350_4931;
`endif

  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // cs_n synchronizer resets to "selected" so a frame already under way at reset
  // is not seen as a new falling edge; cs_n must rise and fall again first.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b0;
      cs_sync_q   <= 1'b0;
      cs_prev_q   <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      sclk_meta_q <= bus.sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= bus.cs_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= bus.mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign cs_fall   = ~cs_sync_q & cs_prev_q;
  assign cs_rise   = cs_sync_q & ~cs_prev_q;

  state_e                state_q, state_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] shift_in_q, shift_in_d;
  logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  addr_inc_q, addr_inc_d;
  logic                  load_pend_q, load_pend_d;
  logic                  id_mode_q, id_mode_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic [DATA_WIDTH-1:0] shift_word;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      addr_inc_q  <= 1'b0;
      load_pend_q <= 1'b0;
      id_mode_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      addr_inc_q  <= addr_inc_d;
      load_pend_q <= load_pend_d;
      id_mode_q   <= id_mode_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_inc_q ? addr_q + ADDR_ONE : addr_q;
    addr_inc_d  = 1'b0;
    load_pend_d = load_pend_q;
    id_mode_d   = id_mode_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    shift_word  = {shift_in_q[DATA_WIDTH-2:0], mosi_sync_q};

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d     = S_CMD;
          bit_cnt_d   = '0;
          shift_in_d  = '0;
          shift_out_d = '0;
          load_pend_d = 1'b0;
          id_mode_d   = 1'b0;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          shift_in_d = shift_word;
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            cmd_d     = shift_word[7:0];
            bit_cnt_d = '0;
            state_d   = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise) begin
          shift_in_d = shift_word;
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d  = '0;
            shift_in_d = '0;
            case (cmd_q)
              CMD_WRITE: begin
                state_d = S_WDATA;
                addr_d  = shift_word[ADDR_WIDTH-1:0];
              end
              CMD_READ: begin
                state_d     = S_RDATA;
                addr_d      = shift_word[ADDR_WIDTH-1:0];
                load_pend_d = 1'b1;
              end
`ifdef SPI_BRIDGE_ID_EN
              CMD_ID: begin
                state_d     = S_RDATA;
                id_mode_d   = 1'b1;
                load_pend_d = 1'b1;
              end
`endif
              default: state_d = S_IGNORE;
            endcase
          end
        end
      end
      S_WDATA: begin
        if (sclk_rise) begin
          shift_in_d = shift_word;
          bit_cnt_d  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = shift_word;
            addr_inc_d  = 1'b1;
          end
        end
      end
      S_RDATA: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            load_pend_d = 1'b1;
            addr_inc_d  = ~id_mode_q;
          end
        end
        // The fetched word is loaded on the falling edge, long after mem_rdata settled.
        if (sclk_fall) begin
          if (load_pend_q) begin
            load_pend_d = 1'b0;
`ifdef SPI_BRIDGE_ID_EN
            shift_out_d = id_mode_q ? ID_WORD : bus.mem_rdata;
`else
            shift_out_d = bus.mem_rdata;
`endif
          end else begin
            shift_out_d = shift_out_q << 1;
          end
        end
      end
      S_IGNORE: begin
        state_d = S_IGNORE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && cs_rise) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      shift_in_d  = '0;
      mem_we_d    = 1'b0;
      load_pend_d = 1'b0;
    end

    cpu_hold_d = (state_q != S_IDLE) || (state_d != S_IDLE);
  end

  assign bus.miso      = (state_q == S_RDATA) && shift_out_q[DATA_WIDTH-1];
  assign bus.miso_oe   = (state_q == S_RDATA);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.cpu_hold  = cpu_hold_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_spi_ram_bridge.sv
// Bench for spi_ram_bridge: bit-banged SPI master, behavioural RAM, write scoreboard.
module tb_spi_ram_bridge;
  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] state_o;

  always #5 clock = ~clock;

  spi_ram_bridge_if bus ();

  spi_ram_bridge dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural single-port RAM with registered read and a bench preload port.
  logic [31:0] ram [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clock) begin
    bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (pre_we) ram[pre_addr] <= pre_data;
  end

  // Write scoreboard and frame-level monitors.
  logic [39:0] exp_q[$];
  logic [31:0] rd_exp_q[$];
  int   unexp_we   = 0;
  int   back2back  = 0;
  int   quiet_viol = 0;
  logic quiet_en   = 1'b0;
  logic prev_we    = 1'b0;

  always @(negedge clock) begin
    if (bus.mem_we) begin
      if (exp_q.size() == 0) unexp_we++;
      else check("we_addr_data", {24'h0, bus.mem_addr, bus.mem_wdata}, {24'h0, exp_q.pop_front()});
      if (prev_we || !bus.cpu_hold) back2back++;
    end
    if (quiet_en && (bus.miso || bus.miso_oe)) quiet_viol++;
    prev_we = bus.mem_we;
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clock);
    pre_we   = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    bus.mosi = b;
    repeat (8) @(negedge clock);
    r = bus.miso;
    bus.sclk = 1'b1;
    repeat (8) @(negedge clock);
    bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_word(input logic [31:0] tx, output logic [31:0] rx);
    for (int i = 31; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_begin();
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic spi_end();
    repeat (8) @(negedge clock);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  logic [7:0]  rxb;
  logic [31:0] rxw;
  logic        rxbit;
  logic [31:0] wr_words [3];
  logic [7:0]  rnd_addr;

  initial begin
    reset    = 1'b0;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;

    // Reset with cs_n toggling.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.cs_n = i[0];
    end
    check("reset_outputs", {17'h0, state_o, bus.miso, bus.miso_oe, bus.mem_we, bus.cpu_hold,
                            bus.mem_addr, bus.mem_wdata}, 64'h0);
    bus.cs_n = 1'b1;
    reset    = 1'b1;
    repeat (6) @(negedge clock);
    check("idle_after_reset", {state_o, bus.cpu_hold, bus.miso_oe}, 5'h0);
    check("no_we_in_reset", unexp_we, 0);

    // Two-word write at 0x10.
    spi_begin();
    spi_byte(8'h02, rxb);
    check("hold_in_frame", bus.cpu_hold, 1'b1);
    spi_byte(8'h10, rxb);
    exp_q.push_back({8'h10, 32'h0000_0003});
    exp_q.push_back({8'h11, 32'h0000_0007});
    spi_word(32'h0000_0003, rxw);
    spi_word(32'h0000_0007, rxw);
    check("hold_end_of_data", bus.cpu_hold, 1'b1);
    spi_end();
    check("write_drained", exp_q.size(), 0);
    check("hold_after_frame", bus.cpu_hold, 1'b0);

    // Read across the 0xFF -> 0x00 wrap.
    preload(8'hFF, 32'hDEAD_BEEF);
    preload(8'h00, 32'h1234_5678);
    rd_exp_q.push_back(32'hDEAD_BEEF);
    rd_exp_q.push_back(32'h1234_5678);
    spi_begin();
    spi_byte(8'h03, rxb);
    spi_byte(8'hFF, rxb);
    for (int w = 0; w < 2; w++) begin
      spi_word($urandom, rxw);
      check("read_wrap_word", rxw, rd_exp_q.pop_front());
    end
    check("miso_oe_read", bus.miso_oe, 1'b1);
    spi_end();
    check("miso_oe_idle", bus.miso_oe, 1'b0);

    // Write aborted after 20 data bits, then a full write to the same address.
    spi_begin();
    spi_byte(8'h02, rxb);
    spi_byte(8'h20, rxb);
    for (int i = 0; i < 20; i++) spi_bit(1'($urandom_range(0, 1)), rxbit);
    spi_end();
    check("abort_no_we", unexp_we, 0);
    wr_words[0] = $urandom;
    exp_q.push_back({8'h20, wr_words[0]});
    spi_begin();
    spi_byte(8'h02, rxb);
    spi_byte(8'h20, rxb);
    spi_word(wr_words[0], rxw);
    spi_end();
    check("rewrite_drained", exp_q.size(), 0);
    spi_begin();
    spi_byte(8'h03, rxb);
    spi_byte(8'h20, rxb);
    spi_word(32'h0, rxw);
    spi_end();
    check("readback_0x20", rxw, wr_words[0]);

    // Reset in the middle of a write frame; cs_n stays low afterwards.
    spi_begin();
    spi_byte(8'h02, rxb);
    spi_byte(8'h30, rxb);
    for (int i = 0; i < 10; i++) spi_bit(1'b1, rxbit);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    spi_word(32'hA5A5_0001, rxw);
    spi_word(32'hA5A5_0002, rxw);
    check("reset_mid_state", state_o, 3'd0);
    spi_end();
    check("reset_mid_no_we", unexp_we, 0);

    // Unknown command.
    quiet_en = 1'b1;
    spi_begin();
    spi_byte(8'h55, rxb);
    spi_byte(8'h00, rxb);
    spi_word($urandom, rxw);
    spi_end();
    quiet_en = 1'b0;
    check("ignore_quiet", quiet_viol, 0);
    check("ignore_no_we", unexp_we, 0);

    // ID command.
`ifdef SPI_BRIDGE_ID_EN
    rd_exp_q.push_back(32'h5350_4931);
    rd_exp_q.push_back(32'h5350_4931);
    spi_begin();
    spi_byte(8'h9F, rxb);
    spi_byte(8'h44, rxb);
    for (int w = 0; w < 2; w++) begin
      spi_word($urandom, rxw);
      check("id_word", rxw, rd_exp_q.pop_front());
    end
    check("id_miso_oe", bus.miso_oe, 1'b1);
    spi_end();
    check("id_no_we", unexp_we, 0);
`else
    quiet_en = 1'b1;
    spi_begin();
    spi_byte(8'h9F, rxb);
    spi_byte(8'h44, rxb);
    spi_word($urandom, rxw);
    spi_end();
    quiet_en = 1'b0;
    check("id_disabled_miso", rxw, 32'h0);
    check("id_disabled_quiet", quiet_viol, 0);
    check("id_disabled_no_we", unexp_we, 0);
`endif

    // Random three-word writes, one starting at 0xFE to cross the wrap, then read back.
    for (int f = 0; f < 2; f++) begin
      rnd_addr = (f == 0) ? 8'hFE : 8'($urandom_range(1, 250));
      spi_begin();
      spi_byte(8'h02, rxb);
      spi_byte(rnd_addr, rxb);
      for (int w = 0; w < 3; w++) begin
        wr_words[w] = $urandom;
        exp_q.push_back({8'(rnd_addr + 8'(w)), wr_words[w]});
        spi_word(wr_words[w], rxw);
      end
      spi_end();
      check("rand_write_drained", exp_q.size(), 0);
      for (int w = 0; w < 3; w++) rd_exp_q.push_back(wr_words[w]);
      spi_begin();
      spi_byte(8'h03, rxb);
      spi_byte(rnd_addr, rxb);
      for (int w = 0; w < 3; w++) begin
        spi_word($urandom, rxw);
        check("rand_readback", rxw, rd_exp_q.pop_front());
      end
      spi_end();
    end

    check("no_stray_we", unexp_we, 0);
    check("we_spacing_and_hold", back2back, 0);
    check("final_idle", {state_o, bus.cpu_hold, bus.miso, bus.miso_oe}, 6'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
